stack_sequencer: RTL and testbench

Controller that sequences the stack pointer register and the 256-word scratch RAM for stack operations: PUSH, POP, CALL, RET and LOAD_SP.
- Accepts one command at a time over a valid/ready handshake.
- Drives the stack pointer's LD/INCR/DECR controls and the scratch RAM address, write enable and data.
- Tracks stack depth, and flags overflow and underflow.
- Sits between the control unit FSM and the stack pointer / scratch RAM datapath.

---
 rtl/stack_pkg.sv | 39 +++
 rtl/stack_sequencer_if.sv | 51 +++++
 rtl/stack_depth_tracker.sv | 76 +++++++
 rtl/stack_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_stack_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// stack_pkg
// Shared definitions for the stack sequencer slice: command opcodes, FSM
// state encoding, address/data/depth widths and small opcode classifiers.
// Used by stack_sequencer_if, stack_depth_tracker and stack_sequencer.
package stack_pkg;

    localparam int SCR_AW        = 8;
    localparam int DEPTH_MAX_DEF = 256;
    localparam int PC_W          = 10;
    localparam int DEPTH_W       = 9;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_CALL    = 3'd3,
        OP_RET     = 3'd4,
        OP_LOAD_SP = 3'd5
    } stack_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_ADDR,
        ST_READ_DATA,
        ST_LOAD
    } stack_state_t;

    // PUSH and CALL both store one word below the current stack pointer.
    function automatic logic is_write_op(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

    // POP and RET both read the word at the current stack pointer.
    function automatic logic is_read_op(input logic [2:0] op);
        return (op == OP_POP) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if
// Bundles every non-clock/reset signal of the stack sequencer.
//   cmd_*     : command handshake from the control unit FSM
//   clr_err   : clears the sticky overflow/underflow flags
//   sp_*      : stack pointer register controls and current value
//   scr_*     : scratch RAM address/write/read data (read is synchronous)
//   rsp_*     : POP/RET result pulse and data
//   depth/ovf/unf : occupancy and sticky error status
// Modport slave is the sequencer; modport master is the surrounding system.
interface stack_sequencer_if import stack_pkg::*; #(parameter int DW = PC_W) ();

    logic                 cmd_valid;
    logic [2:0]           cmd_op;
    logic [DW-1:0]        cmd_data;
    logic                 cmd_ready;
    logic                 clr_err;

    logic [SCR_AW-1:0]    sp_in;
    logic                 sp_ld;
    logic                 sp_incr;
    logic                 sp_decr;
    logic [SCR_AW-1:0]    sp_din;

    logic [SCR_AW-1:0]    scr_addr;
    logic                 scr_we;
    logic [DW-1:0]        scr_din;
    logic [DW-1:0]        scr_dout;

    logic                 rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 rsp_is_pc;

    logic [DEPTH_W-1:0]   depth;
    logic                 ovf;
    logic                 unf;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, clr_err, sp_in, scr_dout,
        output cmd_ready, sp_ld, sp_incr, sp_decr, sp_din,
               scr_addr, scr_we, scr_din,
               rsp_valid, rsp_data, rsp_is_pc, depth, ovf, unf
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, clr_err, sp_in, scr_dout,
        input  cmd_ready, sp_ld, sp_incr, sp_decr, sp_din,
               scr_addr, scr_we, scr_din,
               rsp_valid, rsp_data, rsp_is_pc, depth, ovf, unf
    );

endinterface

// File: rtl/stack_depth_tracker.sv
// stack_depth_tracker
// Counts stacked words and keeps the sticky overflow/underflow flags.
//   clk, rst  : clock, synchronous active-high reset
//   push_req  : a PUSH/CALL was accepted this edge
//   pop_req   : a POP/RET was accepted this edge
//   load_req  : a LOAD_SP was accepted this edge (empties the stack)
//   clr_err   : clears ovf/unf; a simultaneous new error still sets its flag
//   depth     : current word count, saturating at DEPTH_MAX and 0
//   ovf, unf  : sticky error flags
//   is_full, is_empty : used by the sequencer to pick the error path
module stack_depth_tracker import stack_pkg::*; #(
    parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_req,
    input  logic               pop_req,
    input  logic               load_req,
    input  logic               clr_err,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf,
    output logic               unf,
    output logic               is_full,
    output logic               is_empty
);

    localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(DEPTH_MAX);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    assign is_full  = (depth_q >= DEPTH_LIMIT);
    assign is_empty = (depth_q == '0);
    assign depth    = depth_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

    // The clear is applied first so that an error arriving in the same
    // cycle overrides it. A rejected push/pop leaves the count untouched,
    // which is what keeps the depth from ever wrapping.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q & ~clr_err;
        unf_d   = unf_q & ~clr_err;
        if (load_req) begin
            depth_d = '0;
        end else if (push_req) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + 1'b1;
            end
        end else if (pop_req) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - 1'b1;
            end
        end
    end

    // Plain state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer
// Sequences the stack pointer register and the scratch RAM for PUSH, POP,
// CALL, RET and LOAD_SP commands received over a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset (priority over all)
//   bus      : stack_sequencer_if.slave carrying the command handshake,
//              stack pointer controls, scratch RAM port, result pulse and
//              depth/error status
// All strobes are registered: the decision is made on the accept edge and
// the strobe appears during the single following cycle. Depth and the
// error flags update on that same accept edge.
module stack_sequencer import stack_pkg::*; #(
    parameter int DEPTH_MAX = DEPTH_MAX_DEF,
    parameter int DW        = PC_W
) (
    input  logic               clk,
    input  logic               rst,
    stack_sequencer_if.slave   bus
);

    stack_state_t      state_q, state_d;
    logic              sp_ld_q, sp_ld_d;
    logic              sp_incr_q, sp_incr_d;
    logic              sp_decr_q, sp_decr_d;
    logic [SCR_AW-1:0] sp_din_q, sp_din_d;
    logic [SCR_AW-1:0] scr_addr_q, scr_addr_d;
    logic              scr_we_q, scr_we_d;
    logic [DW-1:0]     scr_din_q, scr_din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_is_pc_q, rsp_is_pc_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              is_ret_q, is_ret_d;
    logic [DW-1:0]     rsp_hold_q, rsp_hold_d;

    logic              accept;
    logic              push_req;
    logic              pop_req;
    logic              load_req;
    logic              is_full;
    logic              is_empty;
    logic [DW-1:0]     write_word;
    logic [DW-1:0]     rsp_now;

    assign accept   = bus.cmd_valid & (state_q == ST_IDLE);
    assign push_req = accept & is_write_op(bus.cmd_op);
    assign pop_req  = accept & is_read_op(bus.cmd_op);
    assign load_req = accept & (bus.cmd_op == OP_LOAD_SP);

    // CALL stores the full return PC, PUSH only the low byte.
    assign write_word = (bus.cmd_op == OP_CALL) ? bus.cmd_data
                                                : DW'(bus.cmd_data[7:0]);

    stack_depth_tracker #(.DEPTH_MAX(DEPTH_MAX)) u_depth (
        .clk      (clk),
        .rst      (rst),
        .push_req (push_req),
        .pop_req  (pop_req),
        .load_req (load_req),
        .clr_err  (bus.clr_err),
        .depth    (bus.depth),
        .ovf      (bus.ovf),
        .unf      (bus.unf),
        .is_full  (is_full),
        .is_empty (is_empty)
    );

    // The RAM read is synchronous, so the popped word is only on scr_dout
    // during READ_DATA; it is passed straight through then and captured so
    // rsp_data can hold it afterwards. An underflow forces the result to 0.
    assign rsp_now    = rsp_zero_q ? '0 : bus.scr_dout;
    assign rsp_hold_d = rsp_valid_q ? rsp_now : rsp_hold_q;

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.sp_ld     = sp_ld_q & ~rst;
    assign bus.sp_incr   = sp_incr_q & ~rst;
    assign bus.sp_decr   = sp_decr_q & ~rst;
    assign bus.sp_din    = sp_din_q;
    assign bus.scr_addr  = scr_addr_q;
    assign bus.scr_we    = scr_we_q & ~rst;
    assign bus.scr_din   = scr_din_q;
    assign bus.rsp_valid = rsp_valid_q & ~rst;
    assign bus.rsp_data  = rsp_valid_q ? rsp_now : rsp_hold_q;
    assign bus.rsp_is_pc = rsp_is_pc_q;

    // Next-state and next-output decode. Every output defaults to its idle
    // value so strobes last exactly one cycle. Overflow keeps the FSM in
    // IDLE with no strobes; underflow skips the RAM read and goes straight
    // to READ_DATA with a forced-zero result.
    always_comb begin
        state_d     = state_q;
        sp_ld_d     = 1'b0;
        sp_incr_d   = 1'b0;
        sp_decr_d   = 1'b0;
        sp_din_d    = '0;
        scr_addr_d  = '0;
        scr_we_d    = 1'b0;
        scr_din_d   = '0;
        rsp_valid_d = 1'b0;
        rsp_is_pc_d = 1'b0;
        rsp_zero_d  = 1'b0;
        is_ret_d    = is_ret_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_PUSH, OP_CALL: begin
                            if (!is_full) begin
                                state_d    = ST_WRITE;
                                scr_addr_d = bus.sp_in - 8'd1;
                                scr_we_d   = 1'b1;
                                scr_din_d  = write_word;
                                sp_decr_d  = 1'b1;
                            end
                        end
                        OP_POP, OP_RET: begin
                            if (is_empty) begin
                                state_d     = ST_READ_DATA;
                                rsp_valid_d = 1'b1;
                                rsp_zero_d  = 1'b1;
                                rsp_is_pc_d = (bus.cmd_op == OP_RET);
                            end else begin
                                state_d    = ST_READ_ADDR;
                                scr_addr_d = bus.sp_in;
                                sp_incr_d  = 1'b1;
                                is_ret_d   = (bus.cmd_op == OP_RET);
                            end
                        end
                        OP_LOAD_SP: begin
                            state_d  = ST_LOAD;
                            sp_ld_d  = 1'b1;
                            sp_din_d = bus.cmd_data[7:0];
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_READ_ADDR: begin
                state_d     = ST_READ_DATA;
                rsp_valid_d = 1'b1;
                rsp_is_pc_d = is_ret_q;
            end
            ST_WRITE, ST_LOAD, ST_READ_DATA: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All sequencer state and registered outputs. Reset abandons any
    // in-flight command and returns every output to its idle value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sp_ld_q     <= 1'b0;
            sp_incr_q   <= 1'b0;
            sp_decr_q   <= 1'b0;
            sp_din_q    <= '0;
            scr_addr_q  <= '0;
            scr_we_q    <= 1'b0;
            scr_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_is_pc_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            is_ret_q    <= 1'b0;
            rsp_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            sp_ld_q     <= sp_ld_d;
            sp_incr_q   <= sp_incr_d;
            sp_decr_q   <= sp_decr_d;
            sp_din_q    <= sp_din_d;
            scr_addr_q  <= scr_addr_d;
            scr_we_q    <= scr_we_d;
            scr_din_q   <= scr_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_is_pc_q <= rsp_is_pc_d;
            rsp_zero_q  <= rsp_zero_d;
            is_ret_q    <= is_ret_d;
            rsp_hold_q  <= rsp_hold_d;
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer
// Drives directed commands into stack_sequencer, emulates the stack
// pointer register and synchronous scratch RAM around it, and compares
// every output each cycle against a reference stack model.
module tb_stack_sequencer;
    import stack_pkg::*;

    localparam int DW = 10;

    typedef struct {
        logic          sp_ld;
        logic          sp_incr;
        logic          sp_decr;
        logic [7:0]    sp_din;
        logic [7:0]    scr_addr;
        logic          scr_we;
        logic [DW-1:0] scr_din;
        logic          rsp_valid;
        logic [DW-1:0] rsp_data;
        logic          rsp_is_pc;
        logic          cmd_ready;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stack_sequencer_if #(.DW(DW)) bus ();

    stack_sequencer #(.DEPTH_MAX(256), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment: stack pointer register and 256-word synchronous RAM.
    logic [7:0]    env_sp = 8'h00;
    logic [DW-1:0] env_ram [256];
    logic [DW-1:0] env_dout = '0;

    assign bus.sp_in    = env_sp;
    assign bus.scr_dout = env_dout;

    always @(posedge clk) begin
        if (bus.sp_ld)        env_sp <= bus.sp_din;
        else if (bus.sp_incr) env_sp <= env_sp + 8'd1;
        else if (bus.sp_decr) env_sp <= env_sp - 8'd1;
        if (bus.scr_we) env_ram[bus.scr_addr] <= bus.scr_din;
        env_dout <= env_ram[bus.scr_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic frame_t idle_frame();
        frame_t f;
        f.sp_ld = 0; f.sp_incr = 0; f.sp_decr = 0; f.sp_din = '0;
        f.scr_addr = '0; f.scr_we = 0; f.scr_din = '0;
        f.rsp_valid = 0; f.rsp_data = '0; f.rsp_is_pc = 0;
        f.cmd_ready = 1;
        return f;
    endfunction

    // Reference model: a LIFO of pushed words plus the stack pointer value
    // implied by the strobes. m_cur is what the outputs must show in the
    // cycle after the current edge, m_nxt the cycle after that.
    frame_t        m_cur, m_nxt;
    logic [7:0]    m_sp = 8'h00;
    int            m_depth = 0;
    bit            m_ovf = 0, m_unf = 0;
    logic [DW-1:0] m_hold = '0;
    logic [DW-1:0] m_stack[$];

    always @(posedge clk) begin : model_blk
        bit            acc;
        logic [DW-1:0] val;
        logic [2:0]    op;
        if (rst) begin
            m_cur = idle_frame();
            m_nxt = idle_frame();
            m_depth = 0;
            m_ovf = 0;
            m_unf = 0;
            m_hold = '0;
            m_stack.delete();
        end else begin
            acc = bus.cmd_valid && m_cur.cmd_ready;
            op  = bus.cmd_op;
            if (m_cur.sp_ld)        m_sp = m_cur.sp_din;
            else if (m_cur.sp_incr) m_sp = m_sp + 8'd1;
            else if (m_cur.sp_decr) m_sp = m_sp - 8'd1;
            if (bus.clr_err) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (m_cur.rsp_valid) m_hold = m_cur.rsp_data;
            m_cur = m_nxt;
            m_nxt = idle_frame();
            if (acc) begin
                if (op == 3'd1 || op == 3'd3) begin
                    val = (op == 3'd3) ? bus.cmd_data : {2'b00, bus.cmd_data[7:0]};
                    if (m_depth == 256) begin
                        m_ovf = 1;
                    end else begin
                        m_cur.scr_addr  = m_sp - 8'd1;
                        m_cur.scr_we    = 1;
                        m_cur.scr_din   = val;
                        m_cur.sp_decr   = 1;
                        m_cur.cmd_ready = 0;
                        m_depth++;
                        m_stack.push_back(val);
                    end
                end else if (op == 3'd2 || op == 3'd4) begin
                    if (m_depth == 0) begin
                        m_unf = 1;
                        m_cur.cmd_ready = 0;
                        m_cur.rsp_valid = 1;
                        m_cur.rsp_data  = '0;
                        m_cur.rsp_is_pc = (op == 3'd4);
                    end else begin
                        m_cur.scr_addr  = m_sp;
                        m_cur.sp_incr   = 1;
                        m_cur.cmd_ready = 0;
                        m_depth--;
                        m_nxt.cmd_ready = 0;
                        m_nxt.rsp_valid = 1;
                        m_nxt.rsp_data  = m_stack.pop_back();
                        m_nxt.rsp_is_pc = (op == 3'd4);
                    end
                end else if (op == 3'd5) begin
                    m_cur.sp_ld     = 1;
                    m_cur.sp_din    = bus.cmd_data[7:0];
                    m_cur.cmd_ready = 0;
                    m_depth = 0;
                    m_stack.delete();
                end
            end
        end
    end

    // Compare every output against the model shortly after each edge.
    always @(posedge clk) begin
        #1;
        checkOutput("cmd_ready", bus.cmd_ready, m_cur.cmd_ready);
        checkOutput("sp_ld", bus.sp_ld, m_cur.sp_ld);
        checkOutput("sp_incr", bus.sp_incr, m_cur.sp_incr);
        checkOutput("sp_decr", bus.sp_decr, m_cur.sp_decr);
        checkOutput("sp_din", bus.sp_din, m_cur.sp_din);
        checkOutput("scr_addr", bus.scr_addr, m_cur.scr_addr);
        checkOutput("scr_we", bus.scr_we, m_cur.scr_we);
        checkOutput("scr_din", bus.scr_din, m_cur.scr_din);
        checkOutput("rsp_valid", bus.rsp_valid, m_cur.rsp_valid);
        checkOutput("rsp_data", bus.rsp_data,
                    m_cur.rsp_valid ? m_cur.rsp_data : m_hold);
        checkOutput("rsp_is_pc", bus.rsp_is_pc, m_cur.rsp_is_pc);
        checkOutput("depth", bus.depth, m_depth);
        checkOutput("ovf", bus.ovf, m_ovf);
        checkOutput("unf", bus.unf, m_unf);
    end

    // Present a command at a falling edge, wait (bounded) for acceptance,
    // and return at the falling edge of the cycle after the accept edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] data,
                                 input bit holdValid);
        int waited = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        while (!bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: cmd_ready stayed 0, required 1");
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!holdValid) bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) env_ram[i] = '0;
        m_cur = idle_frame();
        m_nxt = idle_frame();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = '0;
        bus.clr_err   = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_depth", bus.depth, 0);
        checkOutput("reset_ready", bus.cmd_ready, 1);
        checkOutput("reset_ovf", bus.ovf, 0);
        checkOutput("reset_rsp_data", bus.rsp_data, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] push 0x5A with SP 0x00");
        applyStimulus(3'd1, 10'h05A, 0);
        checkOutput("push_addr", bus.scr_addr, 8'hFF);
        checkOutput("push_we", bus.scr_we, 1);
        checkOutput("push_din", bus.scr_din, 10'h05A);
        checkOutput("push_decr", bus.sp_decr, 1);
        checkOutput("push_depth", bus.depth, 1);
        @(negedge clk);
        checkOutput("push_ready_back", bus.cmd_ready, 1);

        $display("[TB] pop back to SP 0x00");
        applyStimulus(3'd2, 10'h000, 0);
        checkOutput("pop_addr", bus.scr_addr, 8'hFF);
        checkOutput("pop_incr", bus.sp_incr, 1);
        @(negedge clk);
        checkOutput("pop_valid", bus.rsp_valid, 1);
        checkOutput("pop_data", bus.rsp_data, 10'h05A);
        checkOutput("pop_is_pc", bus.rsp_is_pc, 0);

        $display("[TB] call 0x2A7 then ret");
        applyStimulus(3'd3, 10'h2A7, 0);
        checkOutput("call_addr", bus.scr_addr, 8'hFF);
        checkOutput("call_din", bus.scr_din, 10'h2A7);
        applyStimulus(3'd4, 10'h000, 0);
        checkOutput("ret_addr", bus.scr_addr, 8'hFF);
        checkOutput("ret_no_valid_yet", bus.rsp_valid, 0);
        @(negedge clk);
        checkOutput("ret_valid", bus.rsp_valid, 1);
        checkOutput("ret_data", bus.rsp_data, 10'h2A7);
        checkOutput("ret_is_pc", bus.rsp_is_pc, 1);
        checkOutput("ret_depth", bus.depth, 0);
        @(negedge clk);
        checkOutput("rsp_hold_data", bus.rsp_data, 10'h2A7);

        $display("[TB] pop on empty stack");
        applyStimulus(3'd2, 10'h000, 0);
        checkOutput("unf_valid", bus.rsp_valid, 1);
        checkOutput("unf_data", bus.rsp_data, 0);
        checkOutput("unf_no_incr", bus.sp_incr, 0);
        checkOutput("unf_flag", bus.unf, 1);
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        checkOutput("unf_cleared", bus.unf, 0);

        $display("[TB] load_sp 0x80 with three words stacked");
        applyStimulus(3'd1, 10'h011, 0);
        applyStimulus(3'd1, 10'h022, 0);
        applyStimulus(3'd1, 10'h033, 0);
        @(negedge clk);
        checkOutput("depth_three", bus.depth, 3);
        applyStimulus(3'd5, 10'h080, 1);
        checkOutput("load_ld", bus.sp_ld, 1);
        checkOutput("load_din", bus.sp_din, 8'h80);
        checkOutput("load_depth", bus.depth, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput("load_not_twice", bus.sp_ld, 0);
        @(negedge clk);
        checkOutput("load_not_twice_late", bus.sp_ld, 0);

        $display("[TB] fill to 256 then overflow");
        for (int i = 0; i < 256; i++) applyStimulus(3'd1, 10'(i), 0);
        @(negedge clk);
        checkOutput("full_depth", bus.depth, 256);
        applyStimulus(3'd1, 10'h03C, 0);
        checkOutput("ovf_no_we", bus.scr_we, 0);
        checkOutput("ovf_no_decr", bus.sp_decr, 0);
        checkOutput("ovf_flag", bus.ovf, 1);
        checkOutput("ovf_depth", bus.depth, 256);
        checkOutput("ovf_ready", bus.cmd_ready, 1);
        applyStimulus(3'd2, 10'h000, 0);
        @(negedge clk);
        checkOutput("after_ovf_pop", bus.rsp_data, 10'h0FF);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        checkOutput("ovf_cleared", bus.ovf, 0);

        $display("[TB] reset during read address phase");
        applyStimulus(3'd2, 10'h000, 0);
        checkOutput("mid_pop_incr", bus.sp_incr, 1);
        rst = 1'b1;
        #1;
        checkOutput("reset_gates_incr", bus.sp_incr, 0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_no_rsp", bus.rsp_valid, 0);
        checkOutput("reset_mid_depth", bus.depth, 0);
        checkOutput("reset_mid_ready", bus.cmd_ready, 1);

        applyStimulus(3'd3, 10'h155, 0);
        applyStimulus(3'd4, 10'h000, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
